// File: rtl/video_burst_fifo_if.sv
// Handshake bundle between the DRAM reader / display side and video_burst_fifo.
// Optional underflow_count is present only when VIDEO_BURST_FIFO_UNDERFLOW_CNT_EN is defined.
`timescale 1ns/1ps
interface video_burst_fifo_if #(
    parameter int DEPTH_LOG2 = 6
) ();
    logic [63:0]         din;
    logic                din_valid;
    logic                din_ready;
    logic                burst_ready;
    logic                flush;
    logic [7:0]          pix_out;
    logic                pix_valid;
    logic                pix_ready;
    logic [DEPTH_LOG2:0] level;
`ifdef VIDEO_BURST_FIFO_UNDERFLOW_CNT_EN
    logic [15:0]         underflow_count;

    modport slave (
        input  din, din_valid, flush, pix_ready,
        output din_ready, burst_ready, pix_out, pix_valid, level, underflow_count
    );
    modport master (
        output din, din_valid, flush, pix_ready,
        input  din_ready, burst_ready, pix_out, pix_valid, level, underflow_count
    );
`else
    modport slave (
        input  din, din_valid, flush, pix_ready,
        output din_ready, burst_ready, pix_out, pix_valid, level
    );
    modport master (
        output din, din_valid, flush, pix_ready,
        input  din_ready, burst_ready, pix_out, pix_valid, level
    );
`endif
endinterface

// File: rtl/video_burst_fifo.sv
// 64-bit word FIFO feeding an 8-bit pixel stream, byte 0 first, with burst-space status.
// Optional macro VIDEO_BURST_FIFO_UNDERFLOW_CNT_EN adds a saturating underflow counter.
`timescale 1ns/1ps
module video_burst_fifo #(
    parameter int DEPTH_LOG2  = 6,
    parameter int BURST_WORDS = 16
) (
    input  logic             ACLK,
    input  logic             rst_n,
    video_burst_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   BURST_CNT = (DEPTH_LOG2 + 1)'(BURST_WORDS);
    localparam logic [DEPTH_LOG2:0]   ZERO_CNT  = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   ONE_CNT   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] ZERO_PTR  = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR   = DEPTH_LOG2'(1);

    logic [63:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [2:0]            byte_idx_q, byte_idx_d;
    logic [DEPTH_LOG2:0]   free_s;
    logic [63:0]           rd_word_s;
    logic                  din_ready_s;
    logic                  pix_valid_s;
    logic                  push_s;
    logic                  pix_take_s;
    logic                  pop_s;

    assign din_ready_s = (count_q != FULL_CNT) && !bus.flush;
    assign pix_valid_s = (count_q != ZERO_CNT) && !bus.flush;
    assign push_s      = bus.din_valid && din_ready_s;
    assign pix_take_s  = pix_valid_s && bus.pix_ready;
    assign pop_s       = pix_take_s && (byte_idx_q == 3'd7);
    assign free_s      = FULL_CNT - count_q;
    assign rd_word_s   = mem_q[rd_ptr_q];

    assign bus.din_ready   = din_ready_s;
    assign bus.pix_valid   = pix_valid_s;
    assign bus.burst_ready = (free_s >= BURST_CNT);
    assign bus.level       = count_q;
    assign bus.pix_out     = rd_word_s[{byte_idx_q, 3'b000} +: 8];

    // Storage write port; contents are deliberately never cleared.
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    // Next-state for pointers, occupancy and byte position; flush wins over push/pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        if (bus.flush) begin
            wr_ptr_d   = ZERO_PTR;
            rd_ptr_d   = ZERO_PTR;
            count_d    = ZERO_CNT;
            byte_idx_d = 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + ONE_PTR;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pix_take_s) begin
                byte_idx_d = byte_idx_q + 3'd1;
            end else begin
                byte_idx_d = byte_idx_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ONE_PTR;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and status registers.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= ZERO_PTR;
            rd_ptr_q   <= ZERO_PTR;
            count_q    <= ZERO_CNT;
            byte_idx_q <= 3'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
        end
    end

`ifdef VIDEO_BURST_FIFO_UNDERFLOW_CNT_EN
    logic        armed_q, armed_d;
    logic [15:0] ufl_q, ufl_d;

    // Counting starts only once the display has taken its first pixel.
    always_comb begin
        armed_d = armed_q;
        ufl_d   = ufl_q;
        if (bus.flush) begin
            armed_d = 1'b0;
            ufl_d   = 16'd0;
        end else begin
            if (pix_take_s) begin
                armed_d = 1'b1;
            end else begin
                armed_d = armed_q;
            end
            if (armed_q && bus.pix_ready && !pix_valid_s && (ufl_q != 16'hFFFF)) begin
                ufl_d = ufl_q + 16'd1;
            end else begin
                ufl_d = ufl_q;
            end
        end
    end

    // Underflow counter registers.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            ufl_q   <= 16'd0;
        end else begin
            armed_q <= armed_d;
            ufl_q   <= ufl_d;
        end
    end

    assign bus.underflow_count = ufl_q;
`endif
endmodule
